branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; the ports SHALL be named clk and reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  request to evaluate one branch
- br_type  in  3  0=beq, 1=bne, 2=blez, 3=bgtz, 4=bltz, 5=bgez; 6 and 7 are illegal
- cond_sel  out  3  select to the branch-condition mux
- cond_in  in  1  selected condition from that mux
- alu_valid  in  1  ALU compare flags stable this cycle
- busy  out  1  evaluation in progress
- pc_write  out  1  one-cycle pulse: branch taken, load PC
- done  out  1  one-cycle pulse: evaluation finished
- taken  out  1  last result, held until the next done
- illegal  out  1  last request had br_type 6 or 7, held until the next done
- timeout  out  1  last request aborted in WAIT, held until the next done

Function
REQ-003 The FSM states SHALL be IDLE, SELECT, WAIT, COMMIT.
REQ-004 IDLE: when start=1 and br_type<=5, the block SHALL latch br_type into cond_sel and go to SELECT.
REQ-005 IDLE: when start=1 and br_type>=6, the block SHALL go to COMMIT with the result taken=0, illegal=1; cond_sel SHALL be unchanged.
REQ-006 SELECT SHALL last exactly one cycle, to let the mux settle, then go to WAIT.
REQ-007 WAIT: in the first cycle with alu_valid=1, the block SHALL sample cond_in as the result and go to COMMIT.
REQ-008 WAIT SHALL keep a 4-bit cycle counter that clears on WAIT entry; if 16 WAIT cycles pass without alu_valid, the block SHALL go to COMMIT with taken=0, timeout=1.
REQ-009 COMMIT SHALL last one cycle: done=1, pc_write equal to the result, taken/illegal/timeout updated; the next state SHALL be IDLE.
REQ-010 Latency for a legal request SHALL be: start sampled in cycle 0, SELECT in cycle 1, WAIT from cycle 2, alu_valid seen in cycle N≥2, done and pc_write in cycle N+1.
REQ-011 For an illegal request, done SHALL assert in the cycle after start, with pc_write=0.
REQ-012 busy SHALL be 1 in SELECT, WAIT and COMMIT, and 0 in IDLE.
REQ-013 start SHALL be ignored whenever busy=1; it is not queued.
REQ-014 cond_sel SHALL be held constant from SELECT through COMMIT, and SHALL keep its last value in IDLE.
REQ-015 pc_write SHALL never assert without done in the same cycle.
REQ-016 start in the COMMIT cycle SHALL be ignored; a new request is accepted from IDLE in the next cycle.

Reset
REQ-017 When reset=1 at a clock edge, the state SHALL become IDLE, the wait counter 0, and cond_sel, busy, pc_write, done, taken, illegal and timeout all 0.
REQ-018 Reset SHALL take priority over every other input, including in mid-WAIT; the pending evaluation is discarded and no done pulse is emitted.

Configuration
REQ-019 With the macro BRANCH_STATS_EN defined, the block SHALL add outputs taken_cnt[15:0] and ntaken_cnt[15:0], each reset to 0.
REQ-020 taken_cnt SHALL increment on each done with pc_write=1; ntaken_cnt SHALL increment on each done with pc_write=0 for a legal request that did not time out.
REQ-021 Both counters SHALL wrap from 0xFFFF to 0x0000.
REQ-022 Without BRANCH_STATS_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Legal taken: start, br_type=0; alu_valid=1 with cond_in=1 in cycle 2 -> cond_sel=0 from cycle 1; done=pc_write=1 in cycle 3; taken=1.
- Delayed not-taken: br_type=3; alu_valid first high in cycle 6 with cond_in=0 -> done in cycle 7, pc_write=0, taken=0, cond_sel=3 throughout.
- Illegal request: start, br_type=7 -> done in cycle 1, illegal=1, pc_write=0, cond_sel unchanged.
- Timeout: br_type=5, alu_valid held 0 -> done after 16 WAIT cycles (cycle 18), timeout=1, pc_write=0.
- Busy and reset: a second start during WAIT is ignored; reset in WAIT -> next cycle busy=0, no done pulse.
- Stats (BRANCH_STATS_EN): 3 taken, 2 not-taken, 1 illegal -> taken_cnt=3, ntaken_cnt=2; preload taken_cnt to 0xFFFF, one taken -> 0x0000.

Source files
------------

// File: rtl/branch_sequencer.sv
// branch_sequencer: sequences one conditional-branch evaluation
//   (select the condition mux, wait for ALU flags, commit the result).
// Latency: legal request done = alu_valid cycle + 1 (first possible at
//   start + 3); illegal request done = start + 1; timeout done = start + 18.
// Backpressure: start is ignored while busy (including COMMIT), never queued.
// Ports: clk, reset (sync, active-high), start/br_type (request),
//   cond_sel/cond_in (condition mux), alu_valid (ALU flags stable),
//   busy, pc_write, done (pulses), taken/illegal/timeout (held results).
// Optional: define BRANCH_STATS_EN to add taken_cnt/ntaken_cnt counters.
module branch_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] br_type,
  output logic [2:0] cond_sel,
  input  logic       cond_in,
  input  logic       alu_valid,
  output logic       busy,
  output logic       pc_write,
  output logic       done,
  output logic       taken,
  output logic       illegal,
  output logic       timeout
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] taken_cnt,
  output logic [15:0] ntaken_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_WAIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] wait_cnt;
  logic       req_legal;
  logic       wait_expired;

  assign req_legal    = (br_type <= 3'd5);
  // Sixteenth WAIT cycle without flags: counter has reached 15.
  assign wait_expired = (wait_cnt == 4'd15);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = req_legal ? S_SELECT : S_COMMIT;
        end
      end
      S_SELECT: state_nxt = S_WAIT;
      S_WAIT: begin
        if (alu_valid || wait_expired) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the result registers are already loaded
  // on entry to COMMIT, so pc_write can follow taken directly.
  always_comb begin
    busy     = (state != S_IDLE);
    done     = (state == S_COMMIT);
    pc_write = (state == S_COMMIT) && taken;
  end

  // Datapath: condition select, wait counter and result registers.
  // Results are written on the transition into COMMIT so they are visible
  // in the done cycle and then held until the next done.
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_sel <= 3'd0;
      wait_cnt <= 4'd0;
      taken    <= 1'b0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (req_legal) begin
              cond_sel <= br_type;
            end else begin
              taken   <= 1'b0;
              illegal <= 1'b1;
              timeout <= 1'b0;
            end
          end
        end
        S_SELECT: begin
          wait_cnt <= 4'd0;
        end
        S_WAIT: begin
          if (alu_valid) begin
            taken   <= cond_in;
            illegal <= 1'b0;
            timeout <= 1'b0;
          end else if (wait_expired) begin
            taken   <= 1'b0;
            illegal <= 1'b0;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  // Outcome counters; both wrap naturally at 16 bits. Illegal and
  // timed-out requests count as neither taken nor not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt  <= 16'd0;
      ntaken_cnt <= 16'd0;
    end else if (state == S_COMMIT) begin
      if (taken) begin
        taken_cnt <= taken_cnt + 16'd1;
      end else if (!illegal && !timeout) begin
        ntaken_cnt <= ntaken_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
module tb_branch_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] br_type;
  logic [2:0] cond_sel;
  logic       cond_in;
  logic       alu_valid;
  logic       busy;
  logic       pc_write;
  logic       done;
  logic       taken;
  logic       illegal;
  logic       timeout;
`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;
  logic [15:0] ntaken_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: architectural results only.
  logic [2:0]  m_cond_sel;
  logic        m_taken;
  logic        m_illegal;
  logic        m_timeout;
  logic [15:0] m_tc;
  logic [15:0] m_nc;

  branch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .br_type   (br_type),
    .cond_sel  (cond_sel),
    .cond_in   (cond_in),
    .alu_valid (alu_valid),
    .busy      (busy),
    .pc_write  (pc_write),
    .done      (done),
    .taken     (taken),
    .illegal   (illegal),
    .timeout   (timeout)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt  (taken_cnt),
    .ntaken_cnt (ntaken_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cond_sel = 3'd0;
    m_taken    = 1'b0;
    m_illegal  = 1'b0;
    m_timeout  = 1'b0;
    m_tc       = 16'd0;
    m_nc       = 16'd0;
  endtask

  // Checks common to every cycle: held results and counters.
  task automatic chk_held(input string tag);
    chk({tag, ".cond_sel"}, {13'd0, cond_sel}, {13'd0, m_cond_sel});
    chk({tag, ".taken"},    {15'd0, taken},    {15'd0, m_taken});
    chk({tag, ".illegal"},  {15'd0, illegal},  {15'd0, m_illegal});
    chk({tag, ".timeout"},  {15'd0, timeout},  {15'd0, m_timeout});
`ifdef BRANCH_STATS_EN
    chk({tag, ".taken_cnt"},  taken_cnt,  m_tc);
    chk({tag, ".ntaken_cnt"}, ntaken_cnt, m_nc);
`endif
  endtask

  // Idle cycles with start low: block must stay quiet.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle.busy",     {15'd0, busy},     16'd0);
      chk("idle.done",     {15'd0, done},     16'd0);
      chk("idle.pc_write", {15'd0, pc_write}, 16'd0);
      chk_held("idle");
      start     = 1'b0;
      br_type   = 3'($urandom_range(0, 7));
      alu_valid = 1'($urandom_range(0, 1));
      cond_in   = 1'($urandom_range(0, 1));
    end
  endtask

  // One request, start in cycle 0. nv = cycle of first alu_valid in WAIT
  // (2..17), 0 = never. noise = random start/br_type while busy.
  // rst_at > 0 = assert reset in that cycle and abandon the request.
  task automatic run_req(input logic [2:0] br, input int nv, input logic cv,
                         input bit noise, input int rst_at);
    int  ce;
    bit  legal;
    bit  res_taken;
    bit  res_timeout;
    legal = (br <= 3'd5);
    if (!legal) begin
      ce = 1; res_taken = 1'b0; res_timeout = 1'b0;
    end else if (nv >= 2 && nv <= 17) begin
      ce = nv + 1; res_taken = cv; res_timeout = 1'b0;
    end else begin
      ce = 18; res_taken = 1'b0; res_timeout = 1'b1;
    end
    for (int c = 0; c <= ce; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("c0.busy", {15'd0, busy}, 16'd0);
        chk("c0.done", {15'd0, done}, 16'd0);
        chk_held("c0");
      end else if (c < ce) begin
        chk("mid.busy",     {15'd0, busy},     16'd1);
        chk("mid.done",     {15'd0, done},     16'd0);
        chk("mid.pc_write", {15'd0, pc_write}, 16'd0);
        chk("mid.cond_sel", {13'd0, cond_sel}, {13'd0, m_cond_sel});
      end else begin
        m_taken   = res_taken;
        m_illegal = !legal;
        m_timeout = res_timeout;
        chk("commit.busy",     {15'd0, busy},     16'd1);
        chk("commit.done",     {15'd0, done},     16'd1);
        chk("commit.pc_write", {15'd0, pc_write}, {15'd0, res_taken});
        chk("commit.taken",    {15'd0, taken},    {15'd0, m_taken});
        chk("commit.illegal",  {15'd0, illegal},  {15'd0, m_illegal});
        chk("commit.timeout",  {15'd0, timeout},  {15'd0, m_timeout});
        chk("commit.cond_sel", {13'd0, cond_sel}, {13'd0, m_cond_sel});
        if (res_taken) m_tc = m_tc + 16'd1;
        else if (legal && !res_timeout) m_nc = m_nc + 16'd1;
      end
      // Drive this cycle's inputs.
      if (c == 0) begin
        start   = 1'b1;
        br_type = br;
        if (legal) m_cond_sel = br;
      end else begin
        start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        br_type = 3'($urandom_range(0, 7));
      end
      if (c == nv) begin
        alu_valid = 1'b1;
        cond_in   = cv;
      end else begin
        cond_in   = 1'($urandom_range(0, 1));
        if (c < 2 || (nv != 0 && c > nv)) alu_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        else alu_valid = 1'b0;
      end
      if (rst_at > 0 && c == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        chk("rst.busy",     {15'd0, busy},     16'd0);
        chk("rst.done",     {15'd0, done},     16'd0);
        chk("rst.pc_write", {15'd0, pc_write}, 16'd0);
        chk_held("rst");
        reset     = 1'b0;
        start     = 1'b0;
        alu_valid = 1'b0;
        return;
      end
    end
    start     = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    start     = 1'b0;
    alu_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    br_type   = 3'd0;
    cond_in   = 1'b0;
    alu_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // Reset state (checked during the idle cycles).
    idle(2);

    // Legal taken, earliest flags.
    run_req(3'd0, 2, 1'b1, 1'b0, 0);
    idle(1);
    // Delayed not-taken.
    run_req(3'd3, 6, 1'b0, 1'b0, 0);
    idle(1);
    // Illegal request: cond_sel keeps 3.
    run_req(3'd7, 0, 1'b0, 1'b0, 0);
    idle(1);
    run_req(3'd6, 0, 1'b0, 1'b1, 0);
    // Timeout.
    run_req(3'd5, 0, 1'b0, 1'b0, 0);
    idle(1);
    // Flags in the very last WAIT cycle.
    run_req(3'd4, 17, 1'b1, 1'b0, 0);
    idle(1);
    // Extra starts while busy and in COMMIT are ignored.
    run_req(3'd1, 9, 1'b1, 1'b1, 0);
    idle(1);
    // Reset mid-WAIT: no done pulse, everything cleared.
    run_req(3'd2, 0, 1'b0, 1'b0, 5);
    idle(3);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      logic [2:0] br;
      int nv;
      br = 3'($urandom_range(0, 7));
      nv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 17));
      run_req(br, nv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      idle(int'($urandom_range(0, 2)));
    end

`ifdef BRANCH_STATS_EN
    apply_reset();
    idle(1);
    for (int i = 0; i < 3; i++) run_req(3'd0, 2, 1'b1, 1'b0, 0);
    for (int i = 0; i < 2; i++) run_req(3'd1, 3, 1'b0, 1'b0, 0);
    run_req(3'd6, 0, 1'b0, 1'b0, 0);
    idle(1);
    chk("stats.taken3",  taken_cnt,  16'd3);
    chk("stats.ntaken2", ntaken_cnt, 16'd2);
    @(negedge clk);
    dut.taken_cnt = 16'hFFFF;
    m_tc = 16'hFFFF;
    idle(1);
    run_req(3'd0, 2, 1'b1, 1'b0, 0);
    idle(1);
    chk("stats.wrap", taken_cnt, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
